// File: rtl/arp_pkg.sv
// Shared ARP field constants and decoder state encoding.
// The transmit-side encoder uses the same field constants.
package arp_pkg;

  localparam logic [15:0] ARP_HW_TYPE      = 16'h0001;
  localparam logic [15:0] ARP_PROT_TYPE    = 16'h0800;
  localparam logic [7:0]  ARP_HW_LEN       = 8'h06;
  localparam logic [7:0]  ARP_PROT_LEN     = 8'h04;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;

  localparam logic [6:0] ARP_BODY_NIBBLES = 7'd56;

  // First nibble index of each field in the body.
  localparam logic [5:0] ARP_HTYPE_IDX = 6'd0;
  localparam logic [5:0] ARP_PTYPE_IDX = 6'd4;
  localparam logic [5:0] ARP_HLEN_IDX  = 6'd8;
  localparam logic [5:0] ARP_PLEN_IDX  = 6'd10;
  localparam logic [5:0] ARP_OPER_IDX  = 6'd12;
  localparam logic [5:0] ARP_SHA_IDX   = 6'd16;
  localparam logic [5:0] ARP_SPA_IDX   = 6'd28;
  localparam logic [5:0] ARP_THA_IDX   = 6'd36;
  localparam logic [5:0] ARP_TPA_IDX   = 6'd48;
  localparam logic [5:0] ARP_LAST_IDX  = 6'(ARP_BODY_NIBBLES - 7'd1);

  typedef enum logic [1:0] {
    IDLE,
    RX,
    DONE,
    DISCARD
  } arp_state_e;

endpackage

// File: rtl/arp_decode_if.sv
// Nibble input stream plus parsed-result bus of the ARP body decoder.
// slave: the decoder side; master: upstream source and result consumer.
interface arp_decode_if;
  logic        ivalid;
  logic [3:0]  din;
  logic        done;
  logic        err;
  logic        is_request;
  logic        is_reply;
  logic        target_match;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [47:0] tha;
  logic [31:0] tpa;

  modport slave (
    input  ivalid, din,
    output done, err, is_request, is_reply, target_match, sha, spa, tha, tpa
  );

  modport master (
    output ivalid, din,
    input  done, err, is_request, is_reply, target_match, sha, spa, tha, tpa
  );
endinterface

// File: rtl/arp_decode.sv
// Nibble-serial ARP body parser: validates header, captures addresses.
// Optional macro ARP_DECODE_TPA_FILTER_EN: publish only bodies whose TPA matches IP_ADDR.
module arp_decode
  import arp_pkg::*;
#(
  parameter logic [31:0] IP_ADDR = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  arp_decode_if.slave  rx
);

  arp_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [3:0]  lo_nib_q;
  logic [15:0] hdr_q;
  logic [47:0] sha_w_q, tha_w_q;
  logic [31:0] spa_w_q, tpa_w_q;

  logic        done_q, err_q, is_request_q, is_reply_q, target_match_q;
  logic [47:0] sha_q, tha_q;
  logic [31:0] spa_q, tpa_q;

  logic [7:0]  rx_byte;
  logic [15:0] hdr_d;
  logic [31:0] tpa_d;
  logic        hdr_bad, tpa_match, publish;

  // Bytes arrive low nibble first, so odd indices complete a byte.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rx_byte   = {rx.din, lo_nib_q};
    hdr_d     = {hdr_q[7:0], rx_byte};
    tpa_d     = {tpa_w_q[23:0], rx_byte};
    tpa_match = (tpa_d == IP_ADDR);
    hdr_bad   = 1'b0;
    case (cnt_q)
      ARP_HTYPE_IDX + 6'd3: hdr_bad = (hdr_d != ARP_HW_TYPE);
      ARP_PTYPE_IDX + 6'd3: hdr_bad = (hdr_d != ARP_PROT_TYPE);
      ARP_HLEN_IDX  + 6'd1: hdr_bad = (rx_byte != ARP_HW_LEN);
      ARP_PLEN_IDX  + 6'd1: hdr_bad = (rx_byte != ARP_PROT_LEN);
      ARP_OPER_IDX  + 6'd3: hdr_bad = (hdr_d != ARP_OPER_REQUEST) && (hdr_d != ARP_OPER_REPLY);
      default:              hdr_bad = 1'b0;
    endcase
`ifdef ARP_DECODE_TPA_FILTER_EN
    publish = tpa_match;
`else
    publish = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lo_nib_q       <= '0;
      hdr_q          <= '0;
      sha_w_q        <= '0;
      spa_w_q        <= '0;
      tha_w_q        <= '0;
      tpa_w_q        <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      is_request_q   <= 1'b0;
      is_reply_q     <= 1'b0;
      target_match_q <= 1'b0;
      sha_q          <= '0;
      spa_q          <= '0;
      tha_q          <= '0;
      tpa_q          <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx.ivalid) begin
            lo_nib_q <= rx.din;
            cnt_q    <= 6'd1;
            state_q  <= RX;
          end
        end
        RX: begin
          if (!rx.ivalid) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (!cnt_q[0]) begin
              lo_nib_q <= rx.din;
            end else if (cnt_q < ARP_SHA_IDX) begin
              hdr_q <= hdr_d;
            end else if (cnt_q < ARP_SPA_IDX) begin
              sha_w_q <= {sha_w_q[39:0], rx_byte};
            end else if (cnt_q < ARP_THA_IDX) begin
              spa_w_q <= {spa_w_q[23:0], rx_byte};
            end else if (cnt_q < ARP_TPA_IDX) begin
              tha_w_q <= {tha_w_q[39:0], rx_byte};
            end else begin
              tpa_w_q <= tpa_d;
            end

            if (hdr_bad) begin
              err_q   <= 1'b1;
              state_q <= DISCARD;
            end else if (cnt_q == ARP_LAST_IDX) begin
              state_q <= DONE;
              // Publish on entry to DONE so the fields are valid with the done pulse.
              if (publish) begin
                done_q         <= 1'b1;
                sha_q          <= sha_w_q;
                spa_q          <= spa_w_q;
                tha_q          <= tha_w_q;
                tpa_q          <= tpa_d;
                is_request_q   <= (hdr_q == ARP_OPER_REQUEST);
                is_reply_q     <= (hdr_q == ARP_OPER_REPLY);
                target_match_q <= tpa_match;
              end
            end
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= rx.ivalid ? DISCARD : IDLE;
        end
        DISCARD: begin
          cnt_q <= '0;
          if (!rx.ivalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx.done         = done_q;
  assign rx.err          = err_q;
  assign rx.is_request   = is_request_q;
  assign rx.is_reply     = is_reply_q;
  assign rx.target_match = target_match_q;
  assign rx.sha          = sha_q;
  assign rx.spa          = spa_q;
  assign rx.tha          = tha_q;
  assign rx.tpa          = tpa_q;

endmodule

// File: tb/tb_arp_decode.sv
// Directed self-checking bench for arp_decode with hand-built ARP bodies.
module tb_arp_decode;

  localparam logic [31:0] MY_IP = 32'h0A000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arp_decode_if bus ();

  arp_decode #(.IP_ADDR(MY_IP)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int done_cyc = -1;
  int err_cyc  = -1;
  int nib_cyc [64];

  logic [47:0] exp_sha, exp_tha;
  logic [31:0] exp_spa, exp_tpa;
  logic [2:0]  exp_flags;
  int d0, e0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (bus.err)  begin err_cnt++;  err_cyc  = cyc; end
    if (bus.done && bus.err) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [223:0] make_body(input logic [15:0] ptype, input logic [15:0] oper,
                                             input logic [47:0] sha, input logic [31:0] spa,
                                             input logic [47:0] tha, input logic [31:0] tpa);
    return {16'h0001, ptype, 8'h06, 8'h04, oper, sha, spa, tha, tpa};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends the first n_nib nibbles of body, then pad filler nibbles, then drops ivalid.
  task automatic send(input logic [223:0] body, input int n_nib, input int pad);
    logic [7:0] b;
    for (int i = 0; i < n_nib; i++) begin
      b = body[223 - 8*(i/2) -: 8];
      bus.din    = (i % 2 == 0) ? b[3:0] : b[7:4];
      bus.ivalid = 1'b1;
      nib_cyc[i] = cyc;
      @(posedge clk); #1;
    end
    for (int i = 0; i < pad; i++) begin
      bus.din    = 4'hF;
      bus.ivalid = 1'b1;
      @(posedge clk); #1;
    end
    bus.ivalid = 1'b0;
    bus.din    = 4'h0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_flags"}, {bus.is_request, bus.is_reply, bus.target_match}, exp_flags);
    check({tag, "_sha"}, bus.sha, exp_sha);
    check({tag, "_spa"}, bus.spa, exp_spa);
    check({tag, "_tha"}, bus.tha, exp_tha);
    check({tag, "_tpa"}, bus.tpa, exp_tpa);
  endtask

  initial begin
    logic [223:0] body;
    bus.ivalid = 1'b0;
    bus.din    = 4'h0;
    rst        = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset state
    exp_flags = 3'b000; exp_sha = '0; exp_spa = '0; exp_tha = '0; exp_tpa = '0;
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check_outputs("rst");

    // Request for our IP
    d0 = done_cnt; e0 = err_cnt;
    body = make_body(16'h0800, 16'h0001, 48'h020000000001, 32'h0A000002, 48'h0, 32'h0A000001);
    send(body, 56, 0);
    check("req_done_now", bus.done, 1'b1);
    exp_flags = 3'b101; exp_sha = 48'h020000000001; exp_spa = 32'h0A000002;
    exp_tha = 48'h0; exp_tpa = 32'h0A000001;
    check_outputs("req");
    idle(2);
    check("req_done_cnt", done_cnt, d0 + 1);
    check("req_err_cnt", err_cnt, e0);
    check("req_latency", done_cyc, nib_cyc[55] + 1);
    check("req_done_low", bus.done, 1'b0);

    // Reply for another host
    d0 = done_cnt; e0 = err_cnt;
    body = make_body(16'h0800, 16'h0002, 48'h0A0B0C0D0E0F, 32'h0A000009, 48'h020000000001, 32'h0A000009);
    send(body, 56, 0);
    idle(2);
`ifdef ARP_DECODE_TPA_FILTER_EN
    check("rep_done_cnt", done_cnt, d0);
`else
    check("rep_done_cnt", done_cnt, d0 + 1);
    exp_flags = 3'b010; exp_sha = 48'h0A0B0C0D0E0F; exp_spa = 32'h0A000009;
    exp_tha = 48'h020000000001; exp_tpa = 32'h0A000009;
`endif
    check("rep_err_cnt", err_cnt, e0);
    check_outputs("rep");

    // Bad PTYPE: err right after nibble 7, rest of body ignored
    d0 = done_cnt; e0 = err_cnt;
    body = make_body(16'h86DD, 16'h0001, 48'h111111111111, 32'h0A000001, 48'h0, MY_IP);
    send(body, 56, 0);
    idle(2);
    check("ptype_err_cnt", err_cnt, e0 + 1);
    check("ptype_err_cyc", err_cyc, nib_cyc[7] + 1);
    check("ptype_done_cnt", done_cnt, d0);
    check_outputs("ptype_hold");

    // Unknown opcode 3: err right after nibble 15
    d0 = done_cnt; e0 = err_cnt;
    body = make_body(16'h0800, 16'h0003, 48'h222222222222, 32'h0A000003, 48'h0, MY_IP);
    send(body, 56, 0);
    idle(2);
    check("oper_err_cnt", err_cnt, e0 + 1);
    check("oper_err_cyc", err_cyc, nib_cyc[15] + 1);
    check("oper_done_cnt", done_cnt, d0);

    // Short body: ivalid drops after 30 nibbles
    d0 = done_cnt; e0 = err_cnt;
    body = make_body(16'h0800, 16'h0001, 48'h333333333333, 32'h0A000033, 48'h0, MY_IP);
    send(body, 30, 0);
    idle(2);
    check("short_err_cnt", err_cnt, e0 + 1);
    check("short_err_cyc", err_cyc, nib_cyc[29] + 2);
    check("short_done_cnt", done_cnt, d0);
    check_outputs("short_hold");

    // Good frame right after the short one
    d0 = done_cnt; e0 = err_cnt;
    body = make_body(16'h0800, 16'h0001, 48'h020000000005, 32'h0A000005, 48'h0, MY_IP);
    send(body, 56, 0);
    idle(2);
    check("after_short_done", done_cnt, d0 + 1);
    check("after_short_err", err_cnt, e0);
    exp_flags = 3'b101; exp_sha = 48'h020000000005; exp_spa = 32'h0A000005;
    exp_tha = 48'h0; exp_tpa = MY_IP;
    check_outputs("after_short");

    // Valid body followed by 8 padding nibbles
    d0 = done_cnt; e0 = err_cnt;
    body = make_body(16'h0800, 16'h0002, 48'h112233445566, 32'hC0A80001, 48'hAABBCCDDEEFF, MY_IP);
    send(body, 56, 8);
    idle(3);
    check("pad_done_cnt", done_cnt, d0 + 1);
    check("pad_err_cnt", err_cnt, e0);
    check("pad_latency", done_cyc, nib_cyc[55] + 1);
    exp_flags = 3'b011; exp_sha = 48'h112233445566; exp_spa = 32'hC0A80001;
    exp_tha = 48'hAABBCCDDEEFF; exp_tpa = MY_IP;
    check_outputs("pad");

    d0 = done_cnt;
    body = make_body(16'h0800, 16'h0001, 48'h020000000001, 32'h0A000002, 48'h0, MY_IP);
    send(body, 56, 0);
    idle(2);
    check("pad_next_done", done_cnt, d0 + 1);
    check("pad_next_sha", bus.sha, 48'h020000000001);

    // Reset in the middle of a frame
    d0 = done_cnt; e0 = err_cnt;
    body = make_body(16'h0800, 16'h0001, 48'h444444444444, 32'h0A000044, 48'h0, MY_IP);
    send(body, 20, 0);
    rst = 1'b1;
    #1;
    exp_flags = 3'b000; exp_sha = '0; exp_spa = '0; exp_tha = '0; exp_tpa = '0;
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_err", bus.err, 1'b0);
    check_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    check("mid_rst_done_cnt", done_cnt, d0);
    check("mid_rst_err_cnt", err_cnt, e0);

    d0 = done_cnt;
    body = make_body(16'h0800, 16'h0001, 48'h020000000007, 32'h0A000007, 48'h0, MY_IP);
    send(body, 56, 0);
    idle(2);
    check("post_rst_done", done_cnt, d0 + 1);
    check("post_rst_spa", bus.spa, 32'h0A000007);

    check("done_err_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arp_decode.md
# arp_decode

Nibble-serial ARP payload parser for the receive path. It sits after the Ethernet frame decoder has stripped the MAC header and EtherType 0x0806, and consumes the 28-byte ARP body as 56 nibbles. It validates the fixed header fields, captures sender and target addresses, and flags requests aimed at our IP. Its outputs drive the ARP reply path and the ARP cache.

## Interface
- IP_ADDR, 32'h0, our IPv4 address, compared against TPA.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- ivalid  input  1  `din` carries a payload nibble this cycle; held high contiguously for one frame body.
- din  input  4  payload nibble.
- done  output  1  one-cycle pulse: a complete, header-valid ARP body was parsed.
- err  output  1  one-cycle pulse: frame aborted (header mismatch, short body, or unknown opcode).
- is_request  output  1  opcode was 0x0001; valid from `done` until next `done`.
- is_reply  output  1  opcode was 0x0002; same validity.
- target_match  output  1  TPA == IP_ADDR; same validity.
- sha  output  48  sender hardware address.
- spa  output  32  sender protocol address.
- tha  output  48  target hardware address.
- tpa  output  32  target protocol address.

## Operation
- Wire order: bytes are most-significant first; within each byte the low nibble comes first, then the high nibble.
- Field nibble indices: HTYPE 0–3 (0x0001), PTYPE 4–7 (0x0800), HLEN 8–9 (0x06), PLEN 10–11 (0x04), OPER 12–15, SHA 16–27, SPA 28–35, THA 36–47, TPA 48–55.
- Nibble counter is 6 bits, 0..55. It increments on each accepted nibble (`ivalid` high in state RX).
- States:
  - IDLE: on `ivalid` high, capture nibble 0, set counter to 1, go to RX.
  - RX: shift nibbles into working registers. Each fixed field is compared when its last nibble arrives. On mismatch, or on OPER not in {1,2}, pulse `err` next cycle and go to DISCARD. After nibble 55 is accepted, go to DONE.
  - DONE: for one cycle, pulse `done` and copy working registers to the `sha`/`spa`/`tha`/`tpa`/`is_*`/`target_match` outputs. Then go to DISCARD if `ivalid` is still high, else IDLE.
  - DISCARD: ignore input (padding/FCS) until `ivalid` is low, then go to IDLE.
- Short body: `ivalid` low in RX before nibble 55. Pulse `err` next cycle, go to IDLE, leave outputs unchanged.
- Outputs change only in DONE. Parsing a new frame never disturbs the previously published result.
- `target_match` is computed from the complete TPA only; partial compares are never exposed.
- `done` and `err` are never high in the same cycle.

## Timing
- Reset values: every output is 0, state IDLE, counter 0, working registers 0.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The remainder of the frame is treated as a new frame only if `ivalid` is seen high in IDLE. Upstream must drop `ivalid` first; that is the upstream contract.
- Latency: `done` is asserted the cycle after nibble 55 is accepted. Output fields are valid on that same cycle.
- `err` on header mismatch comes one cycle after the offending field's last nibble.
- Back-to-back frames need at least one cycle with `ivalid` low between bodies.
- No backpressure: every nibble presented with `ivalid` high is consumed.

## Configuration
- ARP_DECODE_TPA_FILTER_EN defined: `done` pulses only when `target_match` is 1. Parsed bodies with a non-matching TPA end silently, with no `done`, no `err`, and outputs unchanged.
- Not defined: `done` pulses for every valid body, and the consumer uses `target_match` itself.

## Structure
- Shared package `arp_pkg` holds:
  - ARP_HW_TYPE, ARP_PROT_TYPE, ARP_HW_LEN, ARP_PROT_LEN
  - ARP_OPER_REQUEST (16'h0001) and ARP_OPER_REPLY (16'h0002)
  - ARP_BODY_NIBBLES (56) and the per-field start-index constants
  - the decoder state enum (IDLE, RX, DONE, DISCARD)
- The transmit-side encoder uses the same field constants.
- No sub-module; field capture is a shift per field, selected by counter range within this module.

## Test plan
- Request from 02:00:00:00:00:01 / 10.0.0.2 for TPA 10.0.0.1, with IP_ADDR=32'h0A000001 → `done` 1 cycle after nibble 55; `is_request`=1, `target_match`=1, `sha`=48'h020000000001, `spa`=32'h0A000002.
- Reply body (OPER 0x0002), TPA 10.0.0.9 → without the macro: `done`, `is_reply`=1, `target_match`=0. With ARP_DECODE_TPA_FILTER_EN: no `done`, outputs hold the previous values.
- PTYPE 0x86DD → `err` one cycle after nibble 7; no `done`; subsequent nibbles ignored until `ivalid` drops.
- `ivalid` drops after 30 nibbles → `err` next cycle, state IDLE; the following good frame decodes normally.
- Valid body followed by 8 padding nibbles and a gap → one `done`, nothing else; next frame accepted.
- `rst` pulsed at nibble 20 → all outputs 0 immediately; no `done` or `err` for that frame.
